boolean_sweep_ctrl: RTL and testbench
=====================================

BOOLEAN_SWEEP_CTRL -- requirements
Module: boolean_sweep_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles each input vector is held before sampling, legal range 1..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: begin a sweep when sampled high in IDLE.
REQ-005 SHALL have port abort, input, 1: synchronous sweep cancel.
REQ-006 SHALL have port expected, input, 8: golden truth table, where bit i is the expected d for {a,b,c}=i.
REQ-007 SHALL have port d, input, 1: output of the combinational block under sweep.
REQ-008 SHALL have ports a, b, c, output, 1 each: registered drive to the block under sweep, with a as MSB of the index.
REQ-009 SHALL have port busy, output, 1: high in SETTLE and SAMPLE.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at sweep completion.
REQ-011 SHALL have port table_out, output, 8: captured truth table.
REQ-012 SHALL have port pass, output, 1: high when err_count is 0, valid from done until the next start.
REQ-013 SHALL have port err_count, output, 4: number of mismatches, range 0..8.

Function
REQ-014 SHALL implement the states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE: {a,b,c}=000, busy=0; start=1 moves to SETTLE with idx=0, hold=0, table_out=0, err_count=0, pass=0.
REQ-016 SETTLE: drive {a,b,c}=idx, increment hold each cycle, and move to SAMPLE when hold==HOLD_CYCLES-1, so SETTLE lasts exactly HOLD_CYCLES cycles.
REQ-017 SAMPLE: lasts one cycle, keeps {a,b,c}=idx, sets table_out[idx]=d, and increments err_count if d!=expected[idx].
REQ-018 SAMPLE exit: if idx==7 move to DONE; otherwise set idx=idx+1, hold=0 and move to SETTLE.
REQ-019 DONE: lasts one cycle with done=1, pass=(err_count==0) and {a,b,c}=000, then moves to IDLE.
REQ-020 table_out, err_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-021 Latency from the cycle start is sampled to the cycle done is high SHALL be 8*(HOLD_CYCLES+1)+1 cycles (41 at the default).
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; a start held high in IDLE after DONE SHALL begin a new sweep.
REQ-023 abort=1 in SETTLE or SAMPLE SHALL move to IDLE on the next edge, with no done pulse, no table_out or err_count update in that cycle, and pass=0.
REQ-024 If abort and start are high together in IDLE, abort SHALL win and the sweep SHALL not start.
REQ-025 expected SHALL be sampled live at each SAMPLE cycle and is not latched at start.
REQ-026 idx SHALL be 3 bits and never wrap within a sweep; err_count SHALL never exceed 8.

Reset
REQ-027 rst=1 SHALL immediately force IDLE with a=b=c=0, busy=0, done=0, table_out=0, err_count=0, pass=0, idx=0, hold=0, regardless of clk.
REQ-028 Reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-029 After rst deasserts, the first start SHALL be accepted on the first rising edge with rst low.

Structure
REQ-030 Package boolean_sweep_pkg SHALL hold the state encoding (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3), IDX_W=3, CNT_W=8 and ERR_W=4.
REQ-031 The hold counter SHALL be a sub-module sweep_hold_timer with inputs clk, rst, clr, en, limit[7:0] and output expire.
REQ-032 The FSM and capture logic SHALL reside in boolean_sweep_ctrl.

Verification
REQ-033 The bench SHALL cover: DUT d=(a&b)|c, expected=8'hEA, start pulse -> done after 41 cycles, table_out=8'hEA, err_count=0, pass=1.
REQ-034 The bench SHALL cover: same DUT, expected=8'hFF -> table_out=8'hEA, err_count=3, pass=0.
REQ-035 The bench SHALL cover: HOLD_CYCLES=1, d tied to 0, expected=8'h00 -> done after 17 cycles, pass=1, and each {a,b,c} value visible for 2 cycles in order 000..111.
REQ-036 The bench SHALL cover: abort at cycle 10 of a sweep -> busy=0 next cycle, no done pulse, {a,b,c}=000, pass=0.
REQ-037 The bench SHALL cover: rst pulse mid-SETTLE between clock edges -> outputs zero immediately, then a new start gives a full correct sweep.
REQ-038 The bench SHALL cover: start held high for 100 cycles -> back-to-back sweeps separated by exactly one IDLE cycle, with no start accepted while busy.

Source files
------------

// File: rtl/boolean_sweep_pkg.sv
// Shared widths and FSM state encoding for the boolean truth-table sweeper.
package boolean_sweep_pkg;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned ERR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/sweep_hold_timer.sv
// Settle-hold counter: counts while enabled and flags the cycle where count equals limit.
module sweep_hold_timer
    import boolean_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             expire
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = en && (count_q == limit);

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Drives all eight {a,b,c} vectors into a combinational block, captures d per vector
// and compares it against a live golden truth table.
module boolean_sweep_ctrl
    import boolean_sweep_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       expected,
    input  logic             d,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             busy,
    output logic             done,
    output logic [7:0]       table_out,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] abc_q, abc_d;
    logic [7:0]       table_q, table_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pass_q, pass_d;
    logic             hold_clr, hold_en, hold_expire;

    assign hold_en  = (state_q == SETTLE);
    assign hold_clr = (state_q != SETTLE);

    sweep_hold_timer u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr    (hold_clr),
        .en     (hold_en),
        .limit  (HOLD_LIMIT),
        .expire (hold_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start && !abort) state_d = SETTLE;
            SETTLE: begin
                if (abort)            state_d = IDLE;
                else if (hold_expire) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort)             state_d = IDLE;
                else if (idx_q == '1)  state_d = DONE;
                else                   state_d = SETTLE;
            end
            DONE:   state_d = IDLE;
        endcase
    end

    // pass is resolved on the final SAMPLE so it is already valid during the DONE cycle.
    always_comb begin
        idx_d   = idx_q;
        table_d = table_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    idx_d   = '0;
                    table_d = '0;
                    err_d   = '0;
                    pass_d  = 1'b0;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    pass_d = 1'b0;
                end else begin
                    table_d[idx_q] = d;
                    if (d != expected[idx_q]) err_d = err_q + ERR_W'(1);
                    if (idx_q == '1) pass_d = (err_d == '0);
                    else             idx_d  = idx_q + IDX_W'(1);
                end
            end
            SETTLE: if (abort) pass_d = 1'b0;
            DONE:   ;
        endcase
        abc_d = (state_d == SETTLE || state_d == SAMPLE) ? idx_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            abc_q   <= '0;
            table_q <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            table_q <= table_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        {a, b, c} = abc_q;
        busy      = (state_q == SETTLE) || (state_q == SAMPLE);
        done      = (state_q == DONE);
        table_out = table_q;
        err_count = err_q;
        pass      = pass_q;
    end

endmodule

// File: tb/tb_boolean_sweep_ctrl.sv
// Directed bench: sweeps d=(a&b)|c at HOLD_CYCLES=4 and d=0 at HOLD_CYCLES=1.
module tb_boolean_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0 = 1'b0, abort0 = 1'b0, start1 = 1'b0, abort1 = 1'b0;
    logic [7:0] exp0 = 8'hEA, exp1 = 8'h00;
    logic       a0, b0, c0, busy0, done0, pass0, d0;
    logic       a1, b1, c1, busy1, done1, pass1, d1;
    logic [7:0] tab0, tab1;
    logic [3:0] err0, err1;
    int         total = 0;
    int         bad = 0;

    assign d0 = (a0 & b0) | c0;
    assign d1 = 1'b0;

    always #5 clk = ~clk;

    boolean_sweep_ctrl #(.HOLD_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(exp0), .d(d0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0), .table_out(tab0),
        .pass(pass0), .err_count(err0)
    );

    boolean_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(exp1), .d(d1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1), .table_out(tab1),
        .pass(pass1), .err_count(err1)
    );

    task automatic test_reset();
        #2;
        total++;
        if ({a0, b0, c0, busy0, done0, pass0} !== 6'b0 || tab0 !== 8'h00 || err0 !== 4'd0) begin
            bad++;
            $display("FAIL reset_dut0: got abc=%b busy=%b done=%b pass=%b tab=%h err=%0d required all zero",
                     {a0, b0, c0}, busy0, done0, pass0, tab0, err0);
        end
        total++;
        if ({a1, b1, c1, busy1, done1, pass1} !== 6'b0 || tab1 !== 8'h00 || err1 !== 4'd0) begin
            bad++;
            $display("FAIL reset_dut1: got abc=%b busy=%b done=%b pass=%b tab=%h err=%0d required all zero",
                     {a1, b1, c1}, busy1, done1, pass1, tab1, err1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass();
        int lat;
        exp0 = 8'hEA;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; lat = 1;
        while (!done0 && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 41) begin bad++; $display("FAIL pass_latency: got %0d required 41", lat); end
        total++;
        if (tab0 !== 8'hEA) begin bad++; $display("FAIL pass_table: got %h required ea", tab0); end
        total++;
        if (err0 !== 4'd0 || pass0 !== 1'b1) begin
            bad++; $display("FAIL pass_result: got err=%0d pass=%b required err=0 pass=1", err0, pass0);
        end
        total++;
        if ({a0, b0, c0} !== 3'b000 || busy0 !== 1'b0) begin
            bad++; $display("FAIL pass_done_drive: got abc=%b busy=%b required 000/0", {a0, b0, c0}, busy0);
        end
        @(negedge clk);
        total++;
        if (done0 !== 1'b0 || pass0 !== 1'b1 || tab0 !== 8'hEA) begin
            bad++;
            $display("FAIL pass_idle_hold: got done=%b pass=%b tab=%h required 0/1/ea", done0, pass0, tab0);
        end
    endtask

    task automatic test_abort();
        int lat;
        int quiet_bad = 0;
        exp0 = 8'hEA;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; lat = 1;
        total++;
        if (pass0 !== 1'b0 || tab0 !== 8'h00 || busy0 !== 1'b1) begin
            bad++;
            $display("FAIL abort_start_clear: got pass=%b tab=%h busy=%b required 0/00/1", pass0, tab0, busy0);
        end
        while (lat < 10) begin @(negedge clk); lat++; end
        abort0 = 1'b1;
        @(negedge clk); abort0 = 1'b0;
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || {a0, b0, c0} !== 3'b000 || pass0 !== 1'b0) begin
            bad++;
            $display("FAIL abort_exit: got busy=%b done=%b abc=%b pass=%b required 0/0/000/0",
                     busy0, done0, {a0, b0, c0}, pass0);
        end
        total++;
        if (tab0 !== 8'h00 || err0 !== 4'd0) begin
            bad++; $display("FAIL abort_no_capture: got tab=%h err=%0d required 00/0", tab0, err0);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done0 !== 1'b0 || busy0 !== 1'b0) quiet_bad++;
        end
        total++;
        if (quiet_bad !== 0) begin
            bad++; $display("FAIL abort_quiet: got %0d active cycles required 0", quiet_bad);
        end
        start0 = 1'b1; abort0 = 1'b1;
        @(negedge clk); start0 = 1'b0; abort0 = 1'b0;
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL abort_beats_start: got busy=%b required 0", busy0); end
    endtask

    task automatic test_fail();
        int lat;
        exp0 = 8'hFF;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; lat = 1;
        while (!done0 && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 41) begin bad++; $display("FAIL fail_latency: got %0d required 41", lat); end
        total++;
        if (tab0 !== 8'hEA) begin bad++; $display("FAIL fail_table: got %h required ea", tab0); end
        total++;
        if (err0 !== 4'd3 || pass0 !== 1'b0) begin
            bad++; $display("FAIL fail_result: got err=%0d pass=%b required err=3 pass=0", err0, pass0);
        end
        exp0 = 8'hEA;
    endtask

    task automatic test_hold1();
        int lat;
        int seq_bad = 0;
        logic [2:0] ev;
        exp1 = 8'h00;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0; lat = 1;
        while (!done1 && lat < 60) begin
            ev = 3'((lat - 1) / 2);
            if ({a1, b1, c1} !== ev) begin
                seq_bad++;
                $display("FAIL hold1_vector: cycle %0d got abc=%b required %b", lat, {a1, b1, c1}, ev);
            end
            @(negedge clk); lat++;
        end
        total++;
        if (seq_bad !== 0) begin bad++; $display("FAIL hold1_sequence: got %0d wrong cycles required 0", seq_bad); end
        total++;
        if (lat !== 17) begin bad++; $display("FAIL hold1_latency: got %0d required 17", lat); end
        total++;
        if (pass1 !== 1'b1 || err1 !== 4'd0 || tab1 !== 8'h00 || {a1, b1, c1} !== 3'b000) begin
            bad++;
            $display("FAIL hold1_result: got pass=%b err=%0d tab=%h abc=%b required 1/0/00/000",
                     pass1, err1, tab1, {a1, b1, c1});
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        exp0 = 8'hEA;
        @(negedge clk); start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; lat = 1;
        while (lat < 12) begin @(negedge clk); lat++; end
        total++;
        if (tab0 !== 8'h02 || busy0 !== 1'b1 || {a0, b0, c0} !== 3'b010) begin
            bad++;
            $display("FAIL rstmid_pre: got tab=%h busy=%b abc=%b required 02/1/010", tab0, busy0, {a0, b0, c0});
        end
        @(posedge clk); #2 rst = 1'b1; #1;
        total++;
        if ({a0, b0, c0, busy0, done0, pass0} !== 6'b0 || tab0 !== 8'h00 || err0 !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_async: got abc=%b busy=%b done=%b pass=%b tab=%h err=%0d required all zero",
                     {a0, b0, c0}, busy0, done0, pass0, tab0, err0);
        end
        @(negedge clk); rst = 1'b0; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; lat = 1;
        while (!done0 && lat < 100) begin @(negedge clk); lat++; end
        total++;
        if (lat !== 41) begin bad++; $display("FAIL rstmid_latency: got %0d required 41", lat); end
        total++;
        if (tab0 !== 8'hEA || err0 !== 4'd0 || pass0 !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_result: got tab=%h err=%0d pass=%b required ea/0/1", tab0, err0, pass0);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        exp0 = 8'hEA;
        @(negedge clk); start0 = 1'b1;
        for (int lat = 1; lat <= 140; lat++) begin
            @(negedge clk);
            exp_done = (lat % 42 == 41);
            exp_busy = (lat <= 124) && (lat % 42 != 41) && (lat % 42 != 0);
            total++;
            if (done0 !== exp_done || busy0 !== exp_busy) begin
                bad++;
                $display("FAIL b2b_cycle%0d: got done=%b busy=%b required done=%b busy=%b",
                         lat, done0, busy0, exp_done, exp_busy);
            end
            if (exp_done) begin
                total++;
                if (pass0 !== 1'b1 || err0 !== 4'd0 || tab0 !== 8'hEA) begin
                    bad++;
                    $display("FAIL b2b_result%0d: got pass=%b err=%0d tab=%h required 1/0/ea",
                             lat, pass0, err0, tab0);
                end
            end
            if (lat == 100) start0 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_abort();
        test_fail();
        test_hold1();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
